// File: rtl/pipe_scheduler.sv
// Per-frame game-object scheduler: scrolls three pipes and a coin on shadow copies
// during a four-step sweep, then commits them and the BCD score in one cycle.
module pipe_scheduler #(
  parameter int unsigned SPEED   = 2,
  parameter int unsigned SPACING = 220,
  parameter int unsigned PIPE_W  = 50,
  parameter int unsigned GAP     = 100,
  parameter int unsigned HMIN    = 60,
  parameter int unsigned MARIO_X = 40,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        frame_tick,
  input  logic        fail,
  input  logic        coin_hit,
  output logic [31:0] pipe_1,
  output logic [31:0] pipe_2,
  output logic [31:0] pipe_3,
  output logic [31:0] coin,
  output logic [15:0] score,
  output logic        running
);

  localparam logic [9:0] C_SPEED = 10'(SPEED);
  localparam logic [9:0] C_RESP  = 10'(3 * SPACING - SPEED);
  localparam logic [9:0] C_PW    = 10'(PIPE_W);
  localparam logic [9:0] C_MX    = 10'(MARIO_X);
  localparam logic [9:0] C_HMIN  = 10'(HMIN);
  localparam logic [9:0] C_CXOFF = 10'(PIPE_W / 2 - 8);
  localparam logic [9:0] C_CYOFF = 10'(GAP / 2 - 8);
  localparam logic [7:0] C_GAP   = 8'(GAP);
  localparam logic [9:0] C_XINIT [3] = '{10'(300), 10'(300 + SPACING), 10'(300 + 2 * SPACING)};
  localparam logic [9:0] C_HINIT [3] = '{10'd150, 10'd200, 10'd120};

  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN, ST_P1, ST_P2, ST_P3, ST_COIN, ST_COMMIT, ST_FROZEN
  } state_t;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [9:0]  r_x [3];
  logic [9:0]  r_h [3];
  logic [9:0]  r_sx [3];
  logic [9:0]  r_sh [3];
  logic [9:0]  r_cx, r_cy, r_scx, r_scy, r_rx, r_rh;
  logic        r_cv, r_scv, r_rfound, r_inc, r_coin_pend, r_running;
  logic [1:0]  r_pass;
  logic [15:0] r_score;

  logic [1:0]  w_idx;
  logic [9:0]  w_old_x, w_new_x, w_new_h;
  logic        w_resp, w_pass;
  logic [9:0]  w_cx, w_cy;
  logic        w_cv, w_inc;
  logic [2:0]  w_carry;
  logic [4:0]  w_dsum;
  logic [15:0] w_score_nx;

  always_comb begin
    case (r_state)
      ST_P2:   w_idx = 2'd1;
      ST_P3:   w_idx = 2'd2;
      default: w_idx = 2'd0;
    endcase
    w_old_x = r_sx[w_idx];
    w_resp  = w_old_x < C_SPEED;
    w_new_x = w_resp ? w_old_x + C_RESP : w_old_x - C_SPEED;
    w_new_h = C_HMIN + {2'b00, r_lfsr[7:0]};
    w_pass  = !w_resp && (w_old_x + C_PW > C_MX) && (w_new_x + C_PW <= C_MX);
  end

  // A hit arriving in the coin-step cycle itself still retires the coin this frame.
  always_comb begin
    w_cv  = r_scv;
    w_cx  = r_scx;
    w_cy  = r_scy;
    w_inc = 1'b0;
    if (r_coin_pend || coin_hit) begin
      w_cv  = 1'b0;
      w_inc = 1'b1;
    end else if (r_scv && r_scx < C_SPEED) begin
      w_cv = 1'b0;
    end else if (r_scv) begin
      w_cx = r_scx - C_SPEED;
    end
    if (!w_cv && r_rfound) begin
      w_cv = 1'b1;
      w_cx = r_rx + C_CXOFF;
      w_cy = r_rh + C_CYOFF;
    end
  end

  always_comb begin
    w_score_nx = r_score;
    w_carry    = {1'b0, r_pass} + {2'b00, r_inc};
    w_dsum     = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      w_dsum = {1'b0, r_score[4*d +: 4]} + {2'b00, w_carry};
      if (w_dsum > 5'd9) begin
        w_score_nx[4*d +: 4] = 4'(w_dsum - 5'd10);
        w_carry = 3'd1;
      end else begin
        w_score_nx[4*d +: 4] = w_dsum[3:0];
        w_carry = 3'd0;
      end
    end
    if (w_carry != 3'd0) w_score_nx = 16'h9999;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= SEED;
      r_x         <= C_XINIT;
      r_h         <= C_HINIT;
      r_sx        <= C_XINIT;
      r_sh        <= C_HINIT;
      r_cx        <= '0;
      r_cy        <= '0;
      r_cv        <= 1'b0;
      r_scx       <= '0;
      r_scy       <= '0;
      r_scv       <= 1'b0;
      r_rx        <= '0;
      r_rh        <= '0;
      r_rfound    <= 1'b0;
      r_inc       <= 1'b0;
      r_pass      <= '0;
      r_coin_pend <= 1'b0;
      r_score     <= '0;
      r_running   <= 1'b0;
    end else begin
      r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_running <= (r_state != ST_IDLE) && (r_state != ST_FROZEN);
      case (r_state)
        ST_IDLE: if (start) r_state <= ST_RUN;
        ST_RUN: begin
          if (coin_hit) r_coin_pend <= 1'b1;
          if (fail) begin
            r_state <= ST_FROZEN;
          end else if (frame_tick) begin
            r_sx     <= r_x;
            r_sh     <= r_h;
            r_scx    <= r_cx;
            r_scy    <= r_cy;
            r_scv    <= r_cv;
            r_pass   <= '0;
            r_inc    <= 1'b0;
            r_rfound <= 1'b0;
            r_state  <= ST_P1;
          end
        end
        ST_P1, ST_P2, ST_P3: begin
          if (coin_hit) r_coin_pend <= 1'b1;
          if (fail) begin
            r_state <= ST_FROZEN;
          end else begin
            r_sx[w_idx] <= w_new_x;
            if (w_resp) r_sh[w_idx] <= w_new_h;
            if (w_resp && !r_rfound) begin
              r_rfound <= 1'b1;
              r_rx     <= w_new_x;
              r_rh     <= w_new_h;
            end
            if (w_pass) r_pass <= r_pass + 2'd1;
            r_state <= (r_state == ST_P1) ? ST_P2 : (r_state == ST_P2) ? ST_P3 : ST_COIN;
          end
        end
        ST_COIN: begin
          if (coin_hit) r_coin_pend <= 1'b1;
          if (fail) begin
            r_state <= ST_FROZEN;
          end else begin
            r_scx   <= w_cx;
            r_scy   <= w_cy;
            r_scv   <= w_cv;
            r_inc   <= w_inc;
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (fail) begin
            if (coin_hit) r_coin_pend <= 1'b1;
            r_state <= ST_FROZEN;
          end else begin
            r_x         <= r_sx;
            r_h         <= r_sh;
            r_cx        <= r_scx;
            r_cy        <= r_scy;
            r_cv        <= r_scv;
            r_score     <= w_score_nx;
            r_coin_pend <= coin_hit;
            r_state     <= ST_RUN;
          end
        end
        ST_FROZEN: begin
          if (start && !fail) begin
            r_x         <= C_XINIT;
            r_h         <= C_HINIT;
            r_cx        <= '0;
            r_cy        <= '0;
            r_cv        <= 1'b0;
            r_score     <= '0;
            r_coin_pend <= 1'b0;
            r_state     <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pipe_1  = {4'b0000, C_GAP, r_x[0], r_h[0]};
  assign pipe_2  = {4'b0000, C_GAP, r_x[1], r_h[1]};
  assign pipe_3  = {4'b0000, C_GAP, r_x[2], r_h[2]};
  assign coin    = {r_cv, 11'b0, r_cy, r_cx};
  assign score   = r_score;
  assign running = r_running;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed + randomized bench for pipe_scheduler against a frame-level
// reference model (integer positions, decimal score, per-cycle LFSR tracking).
module tb_pipe_scheduler;
  localparam int SPEED = 2, SPACING = 220, PIPE_W = 50, GAP = 100, HMIN = 60, MX = 200;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst, start, frame_tick, fail, coin_hit;
  logic [31:0] pipe_1, pipe_2, pipe_3, coin;
  logic [15:0] score;
  logic running;

  always #5 clk = ~clk;

  pipe_scheduler #(.MARIO_X(MX)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .fail(fail),
    .coin_hit(coin_hit), .pipe_1(pipe_1), .pipe_2(pipe_2), .pipe_3(pipe_3),
    .coin(coin), .score(score), .running(running)
  );

  int mx [3];
  int mh [3];
  int mcx, mcy, msc;
  bit mcv, mpend;
  logic [15:0] lf;
  int nvec, nerr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_init();
    mx[0] = 300; mx[1] = 300 + SPACING; mx[2] = 300 + 2 * SPACING;
    mh[0] = 150; mh[1] = 200; mh[2] = 120;
    mcx = 0; mcy = 0; mcv = 0; msc = 0; mpend = 0;
  endtask

  task automatic clk1();
    @(posedge clk);
    if (rst) lf = SEED;
    else lf = lfsr_next(lf);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic run_exp);
    chk({tag, ".pipe_1"}, pipe_1, {4'b0, 8'(GAP), 10'(mx[0]), 10'(mh[0])});
    chk({tag, ".pipe_2"}, pipe_2, {4'b0, 8'(GAP), 10'(mx[1]), 10'(mh[1])});
    chk({tag, ".pipe_3"}, pipe_3, {4'b0, 8'(GAP), 10'(mx[2]), 10'(mh[2])});
    chk({tag, ".coin"}, coin, {mcv, 11'b0, 10'(mcy), 10'(mcx)});
    chk({tag, ".score"}, {16'b0, score}, {16'b0, to_bcd(msc)});
    chk({tag, ".running"}, {31'b0, running}, {31'b0, run_exp});
  endtask

  // One frame as the game sees it: scroll/respawn each pipe, then coin, then score.
  task automatic model_sweep(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2);
    logic [15:0] lv [3];
    int pass, rk, old, inc;
    lv[0] = l0; lv[1] = l1; lv[2] = l2;
    pass = 0; rk = -1; inc = 0;
    for (int k = 0; k < 3; k++) begin
      if (mx[k] < SPEED) begin
        mx[k] = mx[k] + 3 * SPACING - SPEED;
        mh[k] = HMIN + int'(lv[k][7:0]);
        if (rk < 0) rk = k;
      end else begin
        old = mx[k];
        mx[k] = mx[k] - SPEED;
        if (old + PIPE_W > MX && mx[k] + PIPE_W <= MX) pass++;
      end
    end
    if (mpend) begin
      mcv = 0; inc = 1;
    end else if (mcv && mcx < SPEED) begin
      mcv = 0;
    end else if (mcv) begin
      mcx = mcx - SPEED;
    end
    if (!mcv && rk >= 0) begin
      mcv = 1;
      mcx = mx[rk] + PIPE_W / 2 - 8;
      mcy = mh[rk] + GAP / 2 - 8;
    end
    mpend = 0;
    msc = msc + pass + inc;
    if (msc > 9999) msc = 9999;
  endtask

  task automatic frame(input bit hit_mid, input bit dbl_tick, input string tag);
    logic [15:0] l0, l1, l2;
    frame_tick = 1; clk1(); l0 = lf; frame_tick = 0;
    clk1(); l1 = lf;
    if (dbl_tick) frame_tick = 1;
    if (hit_mid) coin_hit = 1;
    clk1(); l2 = lf;
    frame_tick = 0; coin_hit = 0;
    if (hit_mid) mpend = 1;
    repeat (3) clk1();
    model_sweep(l0, l1, l2);
    check_all(tag, 1'b1);
  endtask

  task automatic idle(input int n, input bit hit);
    for (int i = 0; i < n; i++) begin
      coin_hit = hit && (i == 0);
      clk1();
      if (coin_hit) mpend = 1;
      coin_hit = 0;
    end
  endtask

  initial begin
    int sat;
    rst = 1; start = 0; frame_tick = 0; fail = 0; coin_hit = 0;
    nvec = 0; nerr = 0; lf = SEED;
    model_init();
    repeat (3) clk1();
    rst = 0;
    check_all("reset", 1'b0);

    frame_tick = 1; clk1(); frame_tick = 0; clk1();
    check_all("idle_tick", 1'b0);
    start = 1; clk1(); start = 0;
    check_all("start_edge", 1'b0);
    clk1();
    check_all("run", 1'b1);

    frame(0, 0, "first");
    chk("first.p1x", {22'b0, pipe_1[19:10]}, 32'd298);
    chk("first.p3x", {22'b0, pipe_3[19:10]}, 32'd738);
    frame(0, 1, "dbl_tick");
    chk("dbl_tick.p2x", {22'b0, pipe_2[19:10]}, 32'd516);

    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2), $urandom_range(0, 3) == 0);
      frame($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, "rand");
    end

    // Fail in the second sweep step: frame is dropped, everything freezes.
    frame_tick = 1; clk1(); frame_tick = 0;
    clk1();
    fail = 1; clk1(); fail = 0;
    repeat (2) clk1();
    check_all("frozen", 1'b0);
    frame_tick = 1; clk1(); frame_tick = 0;
    repeat (6) clk1();
    check_all("frozen_tick", 1'b0);
    start = 1; fail = 1; clk1(); start = 0; fail = 0;
    repeat (2) clk1();
    check_all("start_with_fail", 1'b0);
    start = 1; clk1(); start = 0;
    model_init();
    clk1();
    check_all("reload", 1'b1);

    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 2), $urandom_range(0, 2) == 0);
      frame($urandom_range(0, 3) == 0, 0, "post_reload");
    end

    // Reset in the middle of a sweep.
    frame_tick = 1; clk1(); frame_tick = 0;
    clk1(); clk1();
    rst = 1; lf = SEED; model_init();
    #2;
    check_all("mid_reset", 1'b0);
    repeat (2) clk1();
    rst = 0;
    start = 1; clk1(); start = 0;
    clk1();
    check_all("after_reset", 1'b1);

    sat = 0;
    for (int i = 0; i < 11000; i++) begin
      frame(1, 0, "sat");
      if (msc == 9999) sat++;
      if (sat == 3) break;
    end
    chk("sat_score", {16'b0, score}, 32'h0000_9999);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
